// File: rtl/dmem_pkg.sv
// Shared encodings for the data-memory load/store unit: funct3 width codes,
// FSM states and the latency ceiling.
package dmem_pkg;

  localparam logic [2:0] F3_B  = 3'd0;
  localparam logic [2:0] F3_H  = 3'd1;
  localparam logic [2:0] F3_W  = 3'd2;
  localparam logic [2:0] F3_BU = 3'd4;
  localparam logic [2:0] F3_HU = 3'd5;

  localparam int unsigned LATENCY_MAX = 8;

  typedef enum logic [1:0] {INIT, IDLE, WAIT, RESP} state_e;

endpackage

// File: rtl/dmem_lsu_if.sv
// Request/response handshake bundle between the MEM stage and the data memory.
interface dmem_lsu_if #(
  parameter int unsigned ADDR_W = 12
);
  logic              req_valid;
  logic              req_ready;
  logic              req_we;
  logic [2:0]        req_funct3;
  logic [ADDR_W-1:0] req_addr;
  logic [31:0]       req_wdata;
  logic              rsp_valid;
  logic              rsp_ready;
  logic [31:0]       rsp_rdata;
  logic              rsp_err;

  modport master (
    output req_valid, req_we, req_funct3, req_addr, req_wdata, rsp_ready,
    input  req_ready, rsp_valid, rsp_rdata, rsp_err
  );

  modport slave (
    input  req_valid, req_we, req_funct3, req_addr, req_wdata, rsp_ready,
    output req_ready, rsp_valid, rsp_rdata, rsp_err
  );
endinterface

// File: rtl/dmem_align.sv
// Lane steering for RV32I loads/stores: byte enables, replicated store data,
// sign/zero-extended load data and misalignment/illegal-code detection.
module dmem_align
  import dmem_pkg::*;
(
  input  logic [2:0]  funct3_i,
  input  logic [1:0]  addr_lo_i,
  input  logic        we_i,
  input  logic [31:0] wdata_i,
  input  logic [31:0] rword_i,
  output logic [3:0]  be_o,
  output logic [31:0] wdata_o,
  output logic [31:0] rdata_o,
  output logic        err_o
);

  logic [31:0] shifted;

  always_comb begin
    shifted = rword_i >> {addr_lo_i, 3'b000};
    be_o    = '0;
    wdata_o = '0;
    rdata_o = '0;
    err_o   = 1'b0;
    case (funct3_i)
      F3_B: begin
        be_o    = 4'b0001 << addr_lo_i;
        wdata_o = {4{wdata_i[7:0]}};
        rdata_o = {{24{shifted[7]}}, shifted[7:0]};
      end
      F3_H: begin
        err_o   = addr_lo_i[0];
        be_o    = addr_lo_i[1] ? 4'b1100 : 4'b0011;
        wdata_o = {2{wdata_i[15:0]}};
        rdata_o = {{16{shifted[15]}}, shifted[15:0]};
      end
      F3_W: begin
        err_o   = (addr_lo_i != 2'b00);
        be_o    = 4'b1111;
        wdata_o = wdata_i;
        rdata_o = rword_i;
      end
      F3_BU: begin
        err_o   = we_i;
        rdata_o = {24'b0, shifted[7:0]};
      end
      F3_HU: begin
        err_o   = we_i | addr_lo_i[0];
        rdata_o = {16'b0, shifted[15:0]};
      end
      default: err_o = 1'b1;
    endcase
    // An errored or non-store access must never touch memory.
    if (err_o || !we_i) be_o = '0;
    if (err_o) rdata_o = '0;
  end

endmodule

// File: rtl/dmem_lsu.sv
// Handshaked data memory for the MEM stage: zeroing sweep after reset, stores
// commit at acceptance, loads respond LATENCY cycles later, one request in flight.
module dmem_lsu
  import dmem_pkg::*;
#(
  parameter int unsigned ADDR_W  = 12,
  parameter int unsigned LATENCY = 1
) (
  input  logic       clk,
  input  logic       rst,
  dmem_lsu_if.slave  bus,
  output logic       init_done
);

  localparam int unsigned DEPTH    = 2 ** (ADDR_W - 2);
  localparam int unsigned WW       = ADDR_W - 2;
  localparam int unsigned LatInitI = (LATENCY > 1) ? LATENCY - 2 : 0;
  localparam logic [2:0]  LatInit  = 3'(LatInitI);

  state_e            state_q, state_d;
  logic [WW-1:0]     sweep_q, sweep_d;
  logic [2:0]        lat_q, lat_d;
  logic              init_done_q, init_done_d;
  logic              cap_we_q, cap_we_d;
  logic [2:0]        cap_f3_q, cap_f3_d;
  logic [ADDR_W-1:0] cap_addr_q, cap_addr_d;
  logic [31:0]       rdata_q, rdata_d;
  logic              err_q, err_d;
  logic [31:0]       mem_q [DEPTH];

  logic              req_ready, rsp_valid, launch, load_rsp, sweep_wr;
  logic              a_we, a_err;
  logic [2:0]        a_f3;
  logic [ADDR_W-1:0] a_addr;
  logic [WW-1:0]     a_word;
  logic [3:0]        a_be;
  logic [31:0]       a_wdata, a_rdata;

  // The aligner sees the captured request while waiting, otherwise the live one.
  always_comb begin
    a_we   = (state_q == WAIT) ? cap_we_q   : bus.req_we;
    a_f3   = (state_q == WAIT) ? cap_f3_q   : bus.req_funct3;
    a_addr = (state_q == WAIT) ? cap_addr_q : bus.req_addr;
    a_word = a_addr[ADDR_W-1:2];
  end

  dmem_align u_align (
    .funct3_i  (a_f3),
    .addr_lo_i (a_addr[1:0]),
    .we_i      (a_we),
    .wdata_i   (bus.req_wdata),
    .rword_i   (mem_q[a_word]),
    .be_o      (a_be),
    .wdata_o   (a_wdata),
    .rdata_o   (a_rdata),
    .err_o     (a_err)
  );

  always_comb begin
    state_d     = state_q;
    sweep_d     = sweep_q;
    lat_d       = lat_q;
    init_done_d = init_done_q;
    cap_we_d    = cap_we_q;
    cap_f3_d    = cap_f3_q;
    cap_addr_d  = cap_addr_q;
    rdata_d     = rdata_q;
    err_d       = err_q;
    req_ready   = 1'b0;
    rsp_valid   = 1'b0;
    launch      = 1'b0;
    load_rsp    = 1'b0;
    sweep_wr    = 1'b0;
    unique case (state_q)
      INIT: begin
        sweep_wr = 1'b1;
        if (sweep_q == WW'(DEPTH - 1)) begin
          state_d     = IDLE;
          init_done_d = 1'b1;
        end else begin
          sweep_d = sweep_q + 1'b1;
        end
      end
      IDLE: begin
        req_ready = 1'b1;
        launch    = bus.req_valid;
      end
      WAIT: begin
        if (lat_q == 3'd0) begin
          state_d  = RESP;
          load_rsp = 1'b1;
        end else begin
          lat_d = lat_q - 3'd1;
        end
      end
      RESP: begin
        rsp_valid = 1'b1;
        req_ready = bus.rsp_ready;
        if (bus.rsp_ready) begin
          if (bus.req_valid) launch = 1'b1;
          else               state_d = IDLE;
        end
      end
      default: state_d = INIT;
    endcase
    if (launch) begin
      cap_we_d   = bus.req_we;
      cap_f3_d   = bus.req_funct3;
      cap_addr_d = bus.req_addr;
      if (LATENCY == 1) begin
        state_d  = RESP;
        load_rsp = 1'b1;
      end else begin
        state_d = WAIT;
        lat_d   = LatInit;
      end
    end
    if (load_rsp) begin
      err_d   = a_err;
      rdata_d = (a_we || a_err) ? 32'h0 : a_rdata;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= INIT;
      sweep_q     <= '0;
      lat_q       <= '0;
      init_done_q <= 1'b0;
      cap_we_q    <= 1'b0;
      cap_f3_q    <= '0;
      cap_addr_q  <= '0;
      rdata_q     <= '0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      sweep_q     <= sweep_d;
      lat_q       <= lat_d;
      init_done_q <= init_done_d;
      cap_we_q    <= cap_we_d;
      cap_f3_q    <= cap_f3_d;
      cap_addr_q  <= cap_addr_d;
      rdata_q     <= rdata_d;
      err_q       <= err_d;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      if (sweep_wr) begin
        mem_q[sweep_q] <= '0;
      end else if (launch) begin
        for (int i = 0; i < 4; i++) begin
          if (a_be[i]) mem_q[a_word][8*i +: 8] <= a_wdata[8*i +: 8];
        end
      end
    end
  end

  // Outputs are forced quiet while reset is held, even before the first edge.
  assign bus.req_ready = req_ready & ~rst;
  assign bus.rsp_valid = rsp_valid & ~rst;
  assign bus.rsp_rdata = rst ? 32'h0 : rdata_q;
  assign bus.rsp_err   = err_q & ~rst;
  assign init_done     = init_done_q & ~rst;

endmodule

// File: tb/tb_dmem_lsu.sv
// Directed bench for dmem_lsu (ADDR_W = 12, LATENCY = 3).
module tb_dmem_lsu;
  import dmem_pkg::*;

  localparam int unsigned AW    = 12;
  localparam int unsigned LAT   = 3;
  localparam int unsigned DEPTH = 1024;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic init_done;
  int   n_checks = 0;
  int   n_fail   = 0;

  dmem_lsu_if #(.ADDR_W(AW)) bus ();

  dmem_lsu #(.ADDR_W(AW), .LATENCY(LAT)) dut (
    .clk       (clk),
    .rst       (rst),
    .bus       (bus),
    .init_done (init_done)
  );

  always #5 clk = ~clk;

  // Issue one request and collect its response; ok drops if a wait bound expires.
  task automatic do_req(input logic we, input logic [2:0] f3, input logic [AW-1:0] addr,
                        input logic [31:0] wd, output logic [31:0] rd, output logic er,
                        output bit ok);
    int n;
    ok = 1'b1;
    @(negedge clk);
    bus.req_we     = we;
    bus.req_funct3 = f3;
    bus.req_addr   = addr;
    bus.req_wdata  = wd;
    bus.req_valid  = 1'b1;
    bus.rsp_ready  = 1'b1;
    #1;
    n = 0;
    while (bus.req_ready !== 1'b1 && n < 2000) begin
      @(negedge clk); #1; n++;
    end
    if (n >= 2000) ok = 1'b0;
    @(negedge clk);
    bus.req_valid = 1'b0;
    #1;
    n = 0;
    while (bus.rsp_valid !== 1'b1 && n < 50) begin
      @(negedge clk); #1; n++;
    end
    if (n >= 50) ok = 1'b0;
    rd = bus.rsp_rdata;
    er = bus.rsp_err;
  endtask

  task automatic test_reset();
    logic [31:0] rd;
    logic        er;
    bit          ok;
    int          n;
    rst = 1'b1;
    @(negedge clk);
    @(negedge clk);
    #1;
    n_checks++;
    if ({bus.req_ready, bus.rsp_valid, bus.rsp_err, init_done, bus.rsp_rdata} !== 36'h0) begin
      n_fail++;
      $display("FAIL reset_outputs: got rdy=%b vld=%b err=%b done=%b rdata=%h required all 0",
               bus.req_ready, bus.rsp_valid, bus.rsp_err, init_done, bus.rsp_rdata);
    end
    @(negedge clk);
    rst = 1'b0;
    #1;
    n = 0;
    while (bus.req_ready !== 1'b1 && n < 2000) begin
      n_checks++;
      if (init_done !== 1'b0) begin
        n_fail++;
        $display("FAIL init_done_early: got %b required 0 at sweep cycle %0d", init_done, n);
      end
      @(negedge clk); #1; n++;
    end
    n_checks++;
    if (n != DEPTH) begin
      n_fail++;
      $display("FAIL sweep_length: got %0d required %0d", n, DEPTH);
    end
    n_checks++;
    if (init_done !== 1'b1) begin
      n_fail++;
      $display("FAIL init_done: got %b required 1", init_done);
    end
    do_req(1'b0, F3_W, 12'h3FC, 32'h0, rd, er, ok);
    n_checks++;
    if (!ok || rd !== 32'h0 || er !== 1'b0) begin
      n_fail++;
      $display("FAIL lw_0x3fc: got ok=%b rdata=%h err=%b required ok=1 rdata=00000000 err=0",
               ok, rd, er);
    end
  endtask

  task automatic test_extract();
    logic [31:0] rd;
    logic        er;
    bit          ok;
    logic [2:0]  f3s   [4] = '{F3_B, F3_BU, F3_H, F3_HU};
    logic [11:0] addrs [4] = '{12'h013, 12'h012, 12'h012, 12'h010};
    logic [31:0] exps  [4] = '{32'hFFFFFFDE, 32'h000000AD, 32'hFFFFDEAD, 32'h0000BEEF};
    do_req(1'b1, F3_W, 12'h010, 32'hDEADBEEF, rd, er, ok);
    n_checks++;
    if (!ok || rd !== 32'h0 || er !== 1'b0) begin
      n_fail++;
      $display("FAIL sw_rsp: got ok=%b rdata=%h err=%b required ok=1 rdata=0 err=0", ok, rd, er);
    end
    for (int i = 0; i < 4; i++) begin
      do_req(1'b0, f3s[i], addrs[i], 32'h0, rd, er, ok);
      n_checks++;
      if (!ok || rd !== exps[i] || er !== 1'b0) begin
        n_fail++;
        $display("FAIL extract_%0d: got ok=%b rdata=%h err=%b required rdata=%h err=0",
                 i, ok, rd, er, exps[i]);
      end
    end
  endtask

  task automatic test_partial();
    logic [31:0] rd;
    logic        er;
    bit          ok;
    do_req(1'b1, F3_B, 12'h011, 32'hFFFFFF55, rd, er, ok);
    do_req(1'b0, F3_W, 12'h010, 32'h0, rd, er, ok);
    n_checks++;
    if (!ok || rd !== 32'hDEAD55EF || er !== 1'b0) begin
      n_fail++;
      $display("FAIL sb_merge: got ok=%b rdata=%h err=%b required DEAD55EF", ok, rd, er);
    end
    do_req(1'b1, F3_H, 12'h012, 32'hABCD1234, rd, er, ok);
    do_req(1'b0, F3_W, 12'h010, 32'h0, rd, er, ok);
    n_checks++;
    if (!ok || rd !== 32'h123455EF || er !== 1'b0) begin
      n_fail++;
      $display("FAIL sh_merge: got ok=%b rdata=%h err=%b required 123455EF", ok, rd, er);
    end
  endtask

  task automatic test_errors();
    logic [31:0] rd;
    logic        er;
    bit          ok;
    do_req(1'b0, F3_W, 12'h011, 32'h0, rd, er, ok);
    n_checks++;
    if (!ok || rd !== 32'h0 || er !== 1'b1) begin
      n_fail++;
      $display("FAIL lw_misaligned: got ok=%b rdata=%h err=%b required rdata=0 err=1", ok, rd, er);
    end
    do_req(1'b1, F3_H, 12'h013, 32'h0000FFFF, rd, er, ok);
    n_checks++;
    if (!ok || rd !== 32'h0 || er !== 1'b1) begin
      n_fail++;
      $display("FAIL sh_misaligned: got ok=%b rdata=%h err=%b required rdata=0 err=1", ok, rd, er);
    end
    do_req(1'b1, F3_BU, 12'h010, 32'h000000AA, rd, er, ok);
    n_checks++;
    if (!ok || er !== 1'b1) begin
      n_fail++;
      $display("FAIL store_f3_4: got ok=%b err=%b required err=1", ok, er);
    end
    do_req(1'b0, F3_W, 12'h010, 32'h0, rd, er, ok);
    n_checks++;
    if (!ok || rd !== 32'h123455EF || er !== 1'b0) begin
      n_fail++;
      $display("FAIL err_store_no_write: got ok=%b rdata=%h err=%b required 123455EF", ok, rd, er);
    end
    do_req(1'b0, 3'd3, 12'h010, 32'h0, rd, er, ok);
    n_checks++;
    if (!ok || rd !== 32'h0 || er !== 1'b1) begin
      n_fail++;
      $display("FAIL load_f3_3: got ok=%b rdata=%h err=%b required rdata=0 err=1", ok, rd, er);
    end
  endtask

  task automatic test_latency_backpressure();
    int k;
    @(negedge clk);
    bus.req_we     = 1'b0;
    bus.req_funct3 = F3_W;
    bus.req_addr   = 12'h010;
    bus.req_valid  = 1'b1;
    bus.rsp_ready  = 1'b0;
    #1;
    n_checks++;
    if (bus.req_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL idle_ready: got %b required 1", bus.req_ready);
    end
    k = 0;
    do begin
      @(negedge clk); bus.req_valid = 1'b0; #1; k++;
    end while (bus.rsp_valid !== 1'b1 && k < 20);
    n_checks++;
    if (k != LAT) begin
      n_fail++;
      $display("FAIL latency_first: got %0d cycles required %0d", k, LAT);
    end
    for (int i = 0; i < 5; i++) begin
      @(negedge clk); #1;
      n_checks++;
      if (bus.rsp_valid !== 1'b1 || bus.rsp_rdata !== 32'h123455EF || bus.rsp_err !== 1'b0
          || bus.req_ready !== 1'b0) begin
        n_fail++;
        $display("FAIL stall_%0d: got vld=%b rdata=%h err=%b rdy=%b required 1 123455EF 0 0",
                 i, bus.rsp_valid, bus.rsp_rdata, bus.rsp_err, bus.req_ready);
      end
    end
    @(negedge clk);
    bus.rsp_ready  = 1'b1;
    bus.req_valid  = 1'b1;
    bus.req_funct3 = F3_BU;
    bus.req_addr   = 12'h013;
    #1;
    n_checks++;
    if (bus.req_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL resp_ready_passthru: got %b required 1", bus.req_ready);
    end
    k = 0;
    do begin
      @(negedge clk); bus.req_valid = 1'b0; #1; k++;
    end while (bus.rsp_valid !== 1'b1 && k < 20);
    n_checks++;
    if (k != LAT || bus.rsp_rdata !== 32'h00000012 || bus.rsp_err !== 1'b0) begin
      n_fail++;
      $display("FAIL back_to_back: got %0d cycles rdata=%h err=%b required %0d 00000012 0",
               k, bus.rsp_rdata, bus.rsp_err, LAT);
    end
  endtask

  task automatic test_reset_wait();
    logic [31:0] rd;
    logic        er;
    bit          ok;
    bit          saw_rsp;
    int          n;
    @(negedge clk);
    bus.req_we     = 1'b1;
    bus.req_funct3 = F3_W;
    bus.req_addr   = 12'h010;
    bus.req_wdata  = 32'hCAFEF00D;
    bus.req_valid  = 1'b1;
    bus.rsp_ready  = 1'b1;
    #1;
    n_checks++;
    if (bus.req_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL rst_wait_accept: got %b required 1", bus.req_ready);
    end
    @(negedge clk);
    bus.req_valid = 1'b0;
    rst = 1'b1;
    @(negedge clk); #1;
    n_checks++;
    if (bus.rsp_valid !== 1'b0 || init_done !== 1'b0) begin
      n_fail++;
      $display("FAIL rst_wait_quiet: got vld=%b done=%b required 0 0", bus.rsp_valid, init_done);
    end
    rst = 1'b0;
    saw_rsp = 1'b0;
    n = 0;
    while (bus.req_ready !== 1'b1 && n < 2000) begin
      if (bus.rsp_valid === 1'b1) saw_rsp = 1'b1;
      @(negedge clk); #1; n++;
    end
    n_checks++;
    if (saw_rsp || n != DEPTH) begin
      n_fail++;
      $display("FAIL rst_wait_sweep: got stray_rsp=%b sweep=%0d required 0 %0d", saw_rsp, n, DEPTH);
    end
    do_req(1'b0, F3_W, 12'h010, 32'h0, rd, er, ok);
    n_checks++;
    if (!ok || rd !== 32'h0 || er !== 1'b0) begin
      n_fail++;
      $display("FAIL rst_wait_zeroed: got ok=%b rdata=%h err=%b required 00000000 0", ok, rd, er);
    end
  endtask

  initial begin
    bus.req_valid  = 1'b0;
    bus.req_we     = 1'b0;
    bus.req_funct3 = '0;
    bus.req_addr   = '0;
    bus.req_wdata  = '0;
    bus.rsp_ready  = 1'b0;
    test_reset();
    test_extract();
    test_partial();
    test_errors();
    test_latency_backpressure();
    test_reset_wait();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
